// File: rtl/csr_file_if.sv
// CSR access port shared by the pipeline (master) and the CSR file (slave).
// Reads are combinational, so rdata and illegal follow addr/we within the cycle.
interface csr_file_if #(
    parameter int N = 64
);
    logic [11:0]  csr_addr;
    logic         csr_we;
    logic [N-1:0] csr_wdata;
    logic [N-1:0] csr_rdata;
    logic         csr_illegal;

    modport master (
        output csr_addr,
        output csr_we,
        output csr_wdata,
        input  csr_rdata,
        input  csr_illegal
    );

    modport slave (
        input  csr_addr,
        input  csr_we,
        input  csr_wdata,
        output csr_rdata,
        output csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: status/trap registers, cycle and retired-instruction counters.
// Trap entry and mret update mstatus/mepc/mcause with priority over software writes.
module csr_file #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    csr_file_if.slave    bus,
    input  logic         instret,
    input  logic         trap_valid,
    input  logic [N-1:0] trap_cause,
    input  logic [N-1:0] trap_pc,
    input  logic         mret,
    output logic [N-1:0] mtvec_o,
    output logic [N-1:0] mepc_o,
    output logic         mie_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [N-1:0] ZERO = {N{1'b0}};
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    // mtvec and mepc hold word-aligned addresses only
    function automatic logic [N-1:0] align4(input logic [N-1:0] v);
        return {v[N-1:2], 2'b00};
    endfunction

    logic         mie_q,      mie_d;
    logic         mpie_q,     mpie_d;
    logic [N-1:0] mtvec_q,    mtvec_d;
    logic [N-1:0] mscratch_q, mscratch_d;
    logic [N-1:0] mepc_q,     mepc_d;
    logic [N-1:0] mcause_q,   mcause_d;
    logic [N-1:0] mcycle_q,   mcycle_d;
    logic [N-1:0] minstret_q, minstret_d;

    logic [N-1:0] rdata_s;
    logic         mapped_s;
    logic         ro_s;
    logic         illegal_s;
    logic         wr_ok_s;

    // Address decode and combinational read mux
    always_comb begin
        rdata_s  = ZERO;
        mapped_s = 1'b1;
        ro_s     = 1'b0;
        case (bus.csr_addr)
            ADDR_MSTATUS: begin
                rdata_s[3] = mie_q;
                rdata_s[7] = mpie_q;
            end
            ADDR_MTVEC:    rdata_s = mtvec_q;
            ADDR_MSCRATCH: rdata_s = mscratch_q;
            ADDR_MEPC:     rdata_s = mepc_q;
            ADDR_MCAUSE:   rdata_s = mcause_q;
            ADDR_MCYCLE:   rdata_s = mcycle_q;
            ADDR_MINSTRET: rdata_s = minstret_q;
            ADDR_CYCLE: begin
                rdata_s = mcycle_q;
                ro_s    = 1'b1;
            end
            ADDR_INSTRET: begin
                rdata_s = minstret_q;
                ro_s    = 1'b1;
            end
            ADDR_MHARTID: begin
                rdata_s = ZERO;
                ro_s    = 1'b1;
            end
            default: begin
                rdata_s  = ZERO;
                mapped_s = 1'b0;
            end
        endcase
        illegal_s = ~mapped_s | (bus.csr_we & ro_s);
        wr_ok_s   = bus.csr_we & ~illegal_s;
    end

    assign bus.csr_rdata   = rdata_s;
    assign bus.csr_illegal = illegal_s;

    // Next-state: counters, free registers, then the trap > mret > write chain
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + ONE;
        minstret_d = minstret_q;

        if (wr_ok_s && (bus.csr_addr == ADDR_MCYCLE)) begin
            mcycle_d = bus.csr_wdata;
        end else begin
            mcycle_d = mcycle_q + ONE;
        end

        // A trapping instruction does not retire
        if (wr_ok_s && (bus.csr_addr == ADDR_MINSTRET)) begin
            minstret_d = bus.csr_wdata;
        end else if (instret && !trap_valid) begin
            minstret_d = minstret_q + ONE;
        end else begin
            minstret_d = minstret_q;
        end

        if (wr_ok_s && (bus.csr_addr == ADDR_MTVEC)) begin
            mtvec_d = align4(bus.csr_wdata);
        end else begin
            mtvec_d = mtvec_q;
        end

        if (wr_ok_s && (bus.csr_addr == ADDR_MSCRATCH)) begin
            mscratch_d = bus.csr_wdata;
        end else begin
            mscratch_d = mscratch_q;
        end

        if (trap_valid) begin
            mepc_d   = align4(trap_pc);
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_ok_s) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = bus.csr_wdata[3];
                    mpie_d = bus.csr_wdata[7];
                end
                ADDR_MEPC:   mepc_d   = align4(bus.csr_wdata);
                ADDR_MCAUSE: mcause_d = bus.csr_wdata;
                default: begin
                    mie_d = mie_q;
                end
            endcase
        end else begin
            mie_d = mie_q;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= ZERO;
            mscratch_q <= ZERO;
            mepc_q     <= ZERO;
            mcause_q   <= ZERO;
            mcycle_q   <= ZERO;
            minstret_q <= ZERO;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: a per-cycle architectural model predicts reads and
// register outputs; a negedge monitor pops the predictions and compares.
module tb_csr_file;
    localparam int N = 64;

    typedef struct {
        logic [11:0]  addr;
        logic [N-1:0] rdata;
        logic         illegal;
        logic [N-1:0] mtvec;
        logic [N-1:0] mepc;
        logic         mie;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         instret;
    logic         trap_valid;
    logic [N-1:0] trap_cause;
    logic [N-1:0] trap_pc;
    logic         mret;
    logic [N-1:0] mtvec_o;
    logic [N-1:0] mepc_o;
    logic         mie_o;

    csr_file_if #(.N(N)) bus ();

    csr_file #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .instret    (instret),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc),
        .mret       (mret),
        .mtvec_o    (mtvec_o),
        .mepc_o     (mepc_o),
        .mie_o      (mie_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Architectural state of the reference model
    logic         m_mie, m_mpie;
    logic [N-1:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mtvec = '0; m_mscratch = '0; m_mepc = '0;
        m_mcause = '0; m_mcycle = '0; m_minstret = '0;
    endtask

    function automatic bit is_mapped(input logic [11:0] a);
        logic [11:0] tbl [10] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14};
        foreach (tbl[i]) if (tbl[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_ro(input logic [11:0] a);
        return (a == 12'hC00) || (a == 12'hC02) || (a == 12'hF14);
    endfunction

    function automatic logic [N-1:0] model_read(input logic [11:0] a);
        logic [N-1:0] v;
        v = '0;
        if (a == 12'h300) begin v[3] = m_mie; v[7] = m_mpie; end
        if (a == 12'h305) v = m_mtvec;
        if (a == 12'h340) v = m_mscratch;
        if (a == 12'h341) v = m_mepc;
        if (a == 12'h342) v = m_mcause;
        if (a == 12'hB00 || a == 12'hC00) v = m_mcycle;
        if (a == 12'hB02 || a == 12'hC02) v = m_minstret;
        return v;
    endfunction

    // Apply one rising edge to the model using the inputs of that cycle
    task automatic model_edge(input logic [11:0] a, input logic we, input logic [N-1:0] wd,
                              input logic ir, input logic tv, input logic [N-1:0] tc,
                              input logic [N-1:0] tp, input logic mr);
        bit ok;
        logic old_mie, old_mpie;
        ok = we && is_mapped(a) && !is_ro(a);
        old_mie = m_mie; old_mpie = m_mpie;
        m_mcycle = (ok && a == 12'hB00) ? wd : m_mcycle + 64'd1;
        if (ok && a == 12'hB02) m_minstret = wd;
        else if (ir && !tv)     m_minstret = m_minstret + 64'd1;
        if (ok && a == 12'h305) m_mtvec = {wd[N-1:2], 2'b00};
        if (ok && a == 12'h340) m_mscratch = wd;
        if (tv) begin
            m_mepc = {tp[N-1:2], 2'b00}; m_mcause = tc;
            m_mpie = old_mie; m_mie = 1'b0;
        end else if (mr) begin
            m_mie = old_mpie; m_mpie = 1'b1;
        end else if (ok) begin
            if (a == 12'h300) begin m_mie = wd[3]; m_mpie = wd[7]; end
            if (a == 12'h341) m_mepc = {wd[N-1:2], 2'b00};
            if (a == 12'h342) m_mcause = wd;
        end
    endtask

    // One bus cycle: drive, predict, push, let the edge happen, advance the model
    task automatic step(input logic [11:0] a, input logic we, input logic [N-1:0] wd,
                        input logic ir, input logic tv, input logic [N-1:0] tc,
                        input logic [N-1:0] tp, input logic mr);
        exp_t e;
        bus.csr_addr = a; bus.csr_we = we; bus.csr_wdata = wd;
        instret = ir; trap_valid = tv; trap_cause = tc; trap_pc = tp; mret = mr;
        e.addr = a;
        e.rdata = model_read(a);
        e.illegal = !is_mapped(a) || (we && is_ro(a));
        e.mtvec = m_mtvec; e.mepc = m_mepc; e.mie = m_mie;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(a, we, wd, ir, tv, tc, tp, mr);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        step(a, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [N-1:0] wd);
        step(a, 1'b1, wd, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic check_now(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare the prediction for this cycle against the live outputs
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.csr_rdata !== e.rdata || bus.csr_illegal !== e.illegal) begin
                failures++;
                $display("FAIL read@%h: got rdata=%h ill=%b expected rdata=%h ill=%b",
                         e.addr, bus.csr_rdata, bus.csr_illegal, e.rdata, e.illegal);
            end
            checks++;
            if (mtvec_o !== e.mtvec || mepc_o !== e.mepc || mie_o !== e.mie) begin
                failures++;
                $display("FAIL regs@%h: got mtvec=%h mepc=%h mie=%b expected mtvec=%h mepc=%h mie=%b",
                         e.addr, mtvec_o, mepc_o, mie_o, e.mtvec, e.mepc, e.mie);
            end
        end
    end

    logic [11:0] addr_tbl [12] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                   12'hB02, 12'hC00, 12'hC02, 12'hF14, 12'h7FF, 12'h301};

    initial begin
        rst_n = 1'b0;
        bus.csr_addr = 12'h340; bus.csr_we = 1'b1; bus.csr_wdata = 64'h1234;
        instret = 1'b1; trap_valid = 1'b1; trap_cause = 64'd5; trap_pc = 64'h88; mret = 1'b0;
        model_reset();
        // Edges during reset must be ignored entirely
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_mscratch", bus.csr_rdata, '0);
        check_now("reset_mepc", mepc_o, '0);
        check_now("reset_mie", {63'd0, mie_o}, '0);
        rst_n = 1'b1;

        rd(12'hB00);
        rd(12'hB00);
        rd(12'h340);
        wr(12'h340, 64'hDEAD_BEEF);
        rd(12'h340);

        wr(12'hB00, {{(N-1){1'b1}}, 1'b0});
        rd(12'hB00); rd(12'hC00); rd(12'hB00); rd(12'hC00);

        wr(12'hC00, 64'h55);
        rd(12'hB00);
        rd(12'h7FF);
        wr(12'hF14, 64'h1);
        rd(12'hF14);

        wr(12'h300, 64'h8);
        wr(12'h305, 64'h2003);
        step(12'h341, 1'b1, 64'h40, 1'b1, 1'b1, 64'd11, 64'h1003, 1'b0);
        rd(12'h341); rd(12'h342); rd(12'h300); rd(12'hB02);
        step(12'h300, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
        rd(12'h300); rd(12'hB02);
        step(12'h340, 1'b1, 64'h77, 1'b0, 1'b1, 64'd2, 64'h2000, 1'b0);
        rd(12'h340);

        for (int i = 0; i < 400; i++) begin
            logic [11:0]  a;
            logic [N-1:0] wd, tp, tc;
            a  = addr_tbl[$urandom_range(0, 11)];
            wd = {$urandom(), $urandom()};
            tp = {$urandom(), $urandom()};
            tc = {32'd0, $urandom()};
            step(a, 1'($urandom_range(0, 1)), wd, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), tc, tp, ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-run with nonzero state
        wr(12'hB00, 64'h123);
        wr(12'h340, 64'h5A5A);
        wr(12'h300, 64'h8);
        wr(12'h305, 64'h400);
        wr(12'h341, 64'h404);
        rd(12'hB00);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_mcycle", bus.csr_rdata, '0);
        check_now("async_mtvec", mtvec_o, '0);
        check_now("async_mepc", mepc_o, '0);
        check_now("async_mie", {63'd0, mie_o}, '0);
        bus.csr_addr = 12'h340;
        #1;
        check_now("async_mscratch", bus.csr_rdata, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(12'hB00);
        rd(12'hB00);
        rd(12'h340);

        @(negedge clk);
        #1;
        check_now("drain", 64'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter N, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port csr_addr  input  12  CSR address for read and write.
REQ-005 SHALL have port csr_rdata  output  N  combinational read data (old CSR value fed to the CSR ALU operand b).
REQ-006 SHALL have port csr_we  input  1  write strobe, one cycle per CSR instruction.
REQ-007 SHALL have port csr_wdata  input  N  new CSR value (CSR ALU result1).
REQ-008 SHALL have port csr_illegal  output  1  combinational; high when csr_addr is unmapped, or when csr_we=1 and csr_addr is read-only.
REQ-009 SHALL have port instret  input  1  one-cycle pulse per retired instruction.
REQ-010 SHALL have ports trap_valid  input  1; trap_cause  input  N; trap_pc  input  N; trap entry request.
REQ-011 SHALL have port mret  input  1  return-from-trap pulse.
REQ-012 SHALL have ports mtvec_o, mepc_o  output  N and mie_o  output  1  current register values.

Function
REQ-013 SHALL map these CSRs:
- mstatus 0x300: only MIE (bit 3) and MPIE (bit 7) writable; all other bits read 0.
- mtvec 0x305: bits [1:0] read 0.
- mscratch 0x340.
- mepc 0x341: bits [1:0] read 0.
- mcause 0x342.
- mcycle 0xB00 and minstret 0xB02: read/write.
- cycle 0xC00 and instret 0xC02: read-only aliases of mcycle and minstret.
- mhartid 0xF14: read-only, constant 0.
REQ-014 SHALL return 0 on csr_rdata for unmapped addresses.
REQ-015 SHALL provide zero-latency reads; a write takes effect at the next rising edge, so a read in the same cycle as a write returns the old value.
REQ-016 SHALL ignore csr_we (no state change) whenever csr_illegal=1.
REQ-017 SHALL increment mcycle by 1 every cycle, wrapping from 2^N-1 to 0.
REQ-018 SHALL increment minstret by 1 on each cycle with instret=1, with the same wrap.
REQ-019 SHALL give a same-cycle CSR write to mcycle or minstret priority over the increment; the written value is stored exactly, with no +1.
REQ-020 SHALL perform trap entry on trap_valid=1, all at one edge:
- mepc <= trap_pc with bits [1:0] cleared.
- mcause <= trap_cause.
- MPIE <= MIE.
- MIE <= 0.
REQ-021 SHALL perform return on mret=1: MIE <= MPIE, MPIE <= 1.
REQ-022 SHALL apply priority trap_valid > mret > csr_we for mstatus, mepc and mcause; a lower-priority write to those registers in the same cycle is dropped.
REQ-023 SHALL let a csr_we to a register unaffected by the winning trap or mret (e.g. mscratch) still take effect in the same cycle.
REQ-024 SHALL NOT increment minstret on a cycle with trap_valid=1, even if instret=1.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force all registers to 0, including MIE=0 and MPIE=0.
REQ-026 SHALL, while rst_n=0, drive mtvec_o=0, mepc_o=0 and mie_o=0.
REQ-027 SHALL ignore all inputs while rst_n=0; mcycle first increments at the first rising edge after deassertion.
REQ-028 SHALL abandon any write or trap whose edge occurs during reset.

Verification
REQ-029 Write mscratch=0xDEAD_BEEF; read in the same cycle and the next cycle -> rdata=0 in the write cycle, 0xDEAD_BEEF in the next.
REQ-030 Write mcycle=2^N-2, then idle 3 cycles -> reads 2^N-2, 2^N-1, 0, 1 in successive cycles; cycle 0xC00 reads identical values.
REQ-031 Write 0xC00 with 0x55 -> csr_illegal=1 and the counter is unaffected; read 0x7FF -> rdata=0, csr_illegal=1.
REQ-032 Set MIE=1, then trap_valid with trap_pc=0x1003, cause=11, plus a same-cycle csr_we mepc=0x40 -> mepc=0x1000, mcause=11, MIE=0, MPIE=1.
REQ-033 Then mret -> MIE=1, MPIE=1.
REQ-034 Assert rst_n=0 mid-run with mcycle=0x123 and mscratch nonzero -> all outputs and reads become 0 immediately, without waiting for a clock edge.
